// File: rtl/cpu_types_pkg.sv
// Shared types for the two-cache coherence bus: word type, cache count and controller states.
package cpu_types_pkg;

    localparam int CACHES = 2;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        IDLE,
        ARB,
        SNP1,
        SNP2,
        C2C0,
        C2C1,
        MEM0,
        MEM1,
        WB0,
        WB1
    } cohctrl_state_t;

    // Snoops are issued for the whole two-word block.
    function automatic word_t block_addr(input word_t addr);
        return {addr[WORD_W-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to the cache named by ptr.
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] req,
    input  logic       done,
    output logic [1:0] grant,
    output logic       ptr
);

    // NOTE: flops are written with <= so every register samples pre-edge values, whatever the block order.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            ptr <= 1'b0;
        end else if (done) begin
            ptr <= ~ptr;
        end
    end

    // NOTE: grant takes a full default before any conditional write, so no latch can be inferred.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant      = 2'b00;
            grant[ptr] = 1'b1;
        end
    end

endmodule

// File: rtl/coherence_ctrl.sv
// Snooping coherence bus controller for two L1 data caches sharing one memory port.
// Reads snoop the peer cache and take a cache-to-cache transfer when the peer holds the block dirty.
module coherence_ctrl
    import cpu_types_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic [CACHES-1:0] dREN,
    input  logic [CACHES-1:0] dWEN,
    input  word_t             daddr       [CACHES-1:0],
    input  word_t             dstore      [CACHES-1:0],
    input  logic [CACHES-1:0] cctrans,
    input  logic [CACHES-1:0] ccwrite,
    output logic [CACHES-1:0] dwait,
    output word_t             dload       [CACHES-1:0],
    output logic [CACHES-1:0] ccwait,
    output logic [CACHES-1:0] ccinv,
    output word_t             ccsnoopaddr [CACHES-1:0],
    output logic              ramREN,
    output logic              ramWEN,
    output word_t             ramaddr,
    output word_t             ramstore,
    input  word_t             ramload,
    input  logic              ramwait
);

    cohctrl_state_t    state, next_state;
    logic              owner, snp, owner_active, snooping, txn_done, rr_ptr, inv_q;
    logic [CACHES-1:0] req, grant;
    word_t             snoop_addr_q;

    assign req          = cctrans & (dREN | dWEN);
    assign snp          = ~owner;
    assign owner_active = dREN[owner] | dWEN[owner];
    assign snooping     = state inside {SNP1, SNP2, C2C0, C2C1, MEM0, MEM1};
    assign txn_done     = (state != IDLE) && (next_state == IDLE);

    rr_arbiter2 u_arb (
        .CLK   (CLK),
        .nRST  (nRST),
        .req   (req),
        .done  (txn_done),
        .grant (grant),
        .ptr   (rr_ptr)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (|grant) next_state = ARB;
            ARB:     next_state = dWEN[owner] ? WB0 : SNP1;
            SNP1:    next_state = SNP2;
            SNP2:    next_state = ccwrite[snp] ? C2C0 : MEM0;
            C2C0:    if (!ramwait) next_state = C2C1;
            C2C1:    if (!ramwait) next_state = IDLE;
            MEM0:    if (!ramwait) next_state = MEM1;
            MEM1:    if (!ramwait) next_state = IDLE;
            WB0:     if (!ramwait) next_state = WB1;
            WB1:     if (!ramwait) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // An owner that withdraws its request abandons the rest of the transaction.
        if (state != IDLE && !owner_active) next_state = IDLE;
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state        <= IDLE;
            owner        <= 1'b0;
            inv_q        <= 1'b0;
            snoop_addr_q <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && |grant) owner <= grant[1];
            if (state == ARB) begin
                inv_q        <= ccwrite[owner];
                snoop_addr_q <= block_addr(daddr[owner]);
            end
        end
    end

    // Everything is combinational on state and inputs so a word completes in the ramwait=0 cycle.
    always_comb begin
        for (int i = 0; i < CACHES; i++) begin
            dwait[i]       = 1'b0;
            dload[i]       = '0;
            ccwait[i]      = 1'b0;
            ccinv[i]       = 1'b0;
            ccsnoopaddr[i] = '0;
        end
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (!nRST) begin
            dwait = dREN | dWEN;
            if (snooping) begin
                ccwait[snp]      = 1'b1;
                ccinv[snp]       = inv_q;
                ccsnoopaddr[snp] = snoop_addr_q;
            end
            if (owner_active) begin
                unique case (state)
                    WB0, WB1: begin
                        ramWEN       = 1'b1;
                        ramaddr      = daddr[owner];
                        ramstore     = dstore[owner];
                        dwait[owner] = ramwait;
                    end
                    MEM0, MEM1: begin
                        ramREN       = 1'b1;
                        ramaddr      = daddr[owner];
                        dload[owner] = ramload;
                        dwait[owner] = ramwait;
                    end
                    C2C0, C2C1: begin
                        ramWEN       = 1'b1;
                        ramaddr      = daddr[snp];
                        ramstore     = dstore[snp];
                        dload[owner] = dstore[snp];
                        dwait[owner] = ramwait;
                        dwait[snp]   = ramwait;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A tied request in IDLE must hand the bus to the cache named by the round-robin pointer.
    assert property (@(posedge CLK) disable iff (nRST)
        (state == IDLE && req == 2'b11) |=> (owner == $past(rr_ptr)));

endmodule
